// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution front end and core.
package conv_pkg;

  localparam int PIX_W     = 8;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;

  // Tap ordering shared with the convolution core (row-major, top-left first)
  localparam int WIN_TL   = 0;
  localparam int WIN_TM   = 1;
  localparam int WIN_TR   = 2;
  localparam int WIN_ML   = 3;
  localparam int WIN_MM   = 4;
  localparam int WIN_MR   = 5;
  localparam int WIN_BL   = 6;
  localparam int WIN_BM   = 7;
  localparam int WIN_BR   = 8;
  localparam int WIN_TAPS = 9;

  // Counter/address width that stays at least one bit for tiny sizes
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One image row of storage. Read is combinational so the old value at addr is
// available in the same cycle that the write of the new value is committed.
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int DEPTH  = IMG_W_DEF,
  parameter int DATA_W = PIX_W,
  parameter int AW     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Write the new pixel; contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-to-3x3-window generator. Two line buffers supply rows r-1 and r-2;
// per-row delay taps supply columns c-1 and c-2; the incoming column
// {lb1[c], lb0[c], pix_in} is the third (live) tap of each row.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int DATA_W = PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              frame_start,
  output logic              win_valid,
  output logic [DATA_W-1:0] win_0,
  output logic [DATA_W-1:0] win_1,
  output logic [DATA_W-1:0] win_2,
  output logic [DATA_W-1:0] win_3,
  output logic [DATA_W-1:0] win_4,
  output logic [DATA_W-1:0] win_5,
  output logic [DATA_W-1:0] win_6,
  output logic [DATA_W-1:0] win_7,
  output logic [DATA_W-1:0] win_8,
  output logic              frame_done
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  logic [CW-1:0] col_cnt, cur_c;
  logic [RW-1:0] row_cnt, cur_r;
  logic          win_hit, last_pix;

  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  // Registered taps per row: [0] = column c-2, [1] = column c-1
  logic [DATA_W-1:0] top_sr [2];
  logic [DATA_W-1:0] mid_sr [2];
  logic [DATA_W-1:0] bot_sr [2];
  logic [DATA_W-1:0] win_nxt [WIN_TAPS];
  logic [DATA_W-1:0] win_q   [WIN_TAPS];

  // frame_start pins the current pixel to (0,0) whatever the counters say
  assign cur_c    = frame_start ? '0 : col_cnt;
  assign cur_r    = frame_start ? '0 : row_cnt;
  assign win_hit  = pix_valid && (cur_r >= ROW_MIN) && (cur_c >= COL_MIN);
  assign last_pix = (cur_r == ROW_LAST) && (cur_c == COL_LAST);

  conv_line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(CW)) u_lb0 (
    .clk   (clk),
    .en    (pix_valid),
    .addr  (cur_c),
    .wdata (pix_in),
    .rdata (lb0_rd)
  );

  conv_line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(CW)) u_lb1 (
    .clk   (clk),
    .en    (pix_valid),
    .addr  (cur_c),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Raster position counters, advanced only on accepted pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (pix_valid) begin
      if (cur_c == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (cur_r == ROW_LAST) ? '0 : cur_r + 1'b1;
      end else begin
        col_cnt <= cur_c + 1'b1;
        row_cnt <= cur_r;
      end
    end
  end

  // Window as it will look once the incoming column is shifted in
  always_comb begin
    for (int k = 0; k < WIN_TAPS; k++) win_nxt[k] = '0;
    win_nxt[WIN_TL] = top_sr[0];
    win_nxt[WIN_TM] = top_sr[1];
    win_nxt[WIN_TR] = lb1_rd;
    win_nxt[WIN_ML] = mid_sr[0];
    win_nxt[WIN_MM] = mid_sr[1];
    win_nxt[WIN_MR] = lb0_rd;
    win_nxt[WIN_BL] = bot_sr[0];
    win_nxt[WIN_BM] = bot_sr[1];
    win_nxt[WIN_BR] = pix_in;
  end

  // Column delay taps shift left on every accepted pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        top_sr[i] <= '0;
        mid_sr[i] <= '0;
        bot_sr[i] <= '0;
      end
    end else if (pix_valid) begin
      top_sr[0] <= top_sr[1];
      top_sr[1] <= lb1_rd;
      mid_sr[0] <= mid_sr[1];
      mid_sr[1] <= lb0_rd;
      bot_sr[0] <= bot_sr[1];
      bot_sr[1] <= pix_in;
    end
  end

  // Output registers load only on a complete window and hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < WIN_TAPS; k++) win_q[k] <= '0;
    end else begin
      win_valid  <= win_hit;
      frame_done <= win_hit && last_pix;
      if (win_hit) begin
        for (int k = 0; k < WIN_TAPS; k++) win_q[k] <= win_nxt[k];
      end
    end
  end

  assign win_0 = win_q[WIN_TL];
  assign win_1 = win_q[WIN_TM];
  assign win_2 = win_q[WIN_TR];
  assign win_3 = win_q[WIN_ML];
  assign win_4 = win_q[WIN_MM];
  assign win_5 = win_q[WIN_MR];
  assign win_6 = win_q[WIN_BL];
  assign win_7 = win_q[WIN_BM];
  assign win_8 = win_q[WIN_BR];

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized bench for conv_window_gen: a 4x4 instance and a default 28x28
// instance, both checked against an image-array reference model.
module tb_conv_window_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       pv4 = 1'b0, fs4 = 1'b0, pv28 = 1'b0, fs28 = 1'b0;
  logic [7:0] pi4 = '0, pi28 = '0;
  logic       v4, d4, v28, d28;
  logic [7:0] o4  [9];
  logic [7:0] o28 [9];

  conv_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .pix_valid(pv4), .pix_in(pi4), .frame_start(fs4),
    .win_valid(v4),
    .win_0(o4[0]), .win_1(o4[1]), .win_2(o4[2]), .win_3(o4[3]), .win_4(o4[4]),
    .win_5(o4[5]), .win_6(o4[6]), .win_7(o4[7]), .win_8(o4[8]),
    .frame_done(d4)
  );

  conv_window_gen dut28 (
    .clk(clk), .rst(rst), .pix_valid(pv28), .pix_in(pi28), .frame_start(fs28),
    .win_valid(v28),
    .win_0(o28[0]), .win_1(o28[1]), .win_2(o28[2]), .win_3(o28[3]), .win_4(o28[4]),
    .win_5(o28[5]), .win_6(o28[6]), .win_7(o28[7]), .win_8(o28[8]),
    .frame_done(d28)
  );

  int checks = 0;
  int errors = 0;

  // selected DUT and its image geometry
  int sel = 0;
  int img_w = 4;
  int img_h = 4;

  // reference model: raster position plus the pixels of the current frame
  int          mr = 0, mc = 0;
  logic [7:0]  img [28][28];
  logic        exp_v = 1'b0, exp_d = 1'b0;
  logic [71:0] exp_w = '0;

  // per-scenario observations
  int          nwin = 0, ndone = 0;
  logic [71:0] wq [$];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [71:0] pack9(input logic [7:0] a [9]);
    logic [71:0] p;
    p = '0;
    for (int k = 0; k < 9; k++) p[71-8*k -: 8] = a[k];
    return p;
  endfunction

  task automatic model_reset();
    mr = 0; mc = 0;
    exp_v = 1'b0; exp_d = 1'b0; exp_w = '0;
  endtask

  task automatic model_accept(input logic [7:0] p, input logic fs);
    if (fs) begin mr = 0; mc = 0; end
    img[mr][mc] = p;
    exp_v = (mr >= 2) && (mc >= 2);
    exp_d = exp_v && (mr == img_h - 1) && (mc == img_w - 1);
    if (exp_v)
      for (int k = 0; k < 9; k++) exp_w[71-8*k -: 8] = img[mr - 2 + k / 3][mc - 2 + k % 3];
    mc++;
    if (mc == img_w) begin
      mc = 0;
      mr++;
      if (mr == img_h) mr = 0;
    end
  endtask

  task automatic compare_outputs();
    logic        ov, od;
    logic [71:0] ow;
    ov = (sel == 0) ? v4 : v28;
    od = (sel == 0) ? d4 : d28;
    ow = (sel == 0) ? pack9(o4) : pack9(o28);
    check("win_valid", {71'd0, ov}, {71'd0, exp_v});
    check("frame_done", {71'd0, od}, {71'd0, exp_d});
    check("window", ow, exp_w);
    if (ov) begin nwin++; wq.push_back(ow); end
    if (od) ndone++;
  endtask

  task automatic drive(input logic v, input logic [7:0] p, input logic fs);
    if (sel == 0) begin
      pv4 = v; pi4 = p; fs4 = fs; pv28 = 1'b0; fs28 = 1'b0;
    end else begin
      pv28 = v; pi28 = p; fs28 = fs; pv4 = 1'b0; fs4 = 1'b0;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] p, input logic fs);
    drive(v, p, fs);
    if (v) model_accept(p, fs);
    else begin exp_v = 1'b0; exp_d = 1'b0; end
    @(posedge clk); #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    drive(1'b0, 8'($urandom), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    compare_outputs();
  endtask

  task automatic gap(input int gap_pct);
    int n;
    n = 0;
    while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct && n < 4) begin
      step(1'b0, 8'($urandom), 1'($urandom));
      n++;
    end
  endtask

  task automatic start_scn();
    nwin = 0; ndone = 0; wq.delete();
  endtask

  // base >= 0: pixel i gets base+i; base < 0: random pixels
  task automatic send_frame(input int base, input int gap_pct, input logic fs_first);
    for (int i = 0; i < img_w * img_h; i++) begin
      gap(gap_pct);
      step(1'b1, (base < 0) ? 8'($urandom) : 8'(base + i), fs_first && (i == 0));
    end
  endtask

  initial begin
    // reset state of both instances
    sel = 1; img_w = 28; img_h = 28;
    do_reset();
    sel = 0; img_w = 4; img_h = 4;
    do_reset();
    check("reset_valid", {71'd0, v4}, 72'd0);

    // contiguous 1..16
    start_scn();
    send_frame(1, 0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    check("s1_count", 72'(nwin), 72'd4);
    check("s1_done", 72'(ndone), 72'd1);
    check("s1_first", (wq.size() > 0) ? wq[0] : '0, 72'h01_02_03_05_06_07_09_0A_0B);
    check("s1_last", (wq.size() > 3) ? wq[3] : '0, 72'h06_07_08_0A_0B_0C_0E_0F_10);

    // same frame with random valid gaps
    start_scn();
    send_frame(1, 40, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    check("s2_count", 72'(nwin), 72'd4);
    check("s2_first", (wq.size() > 0) ? wq[0] : '0, 72'h01_02_03_05_06_07_09_0A_0B);
    check("s2_last", (wq.size() > 3) ? wq[3] : '0, 72'h06_07_08_0A_0B_0C_0E_0F_10);

    // back-to-back frames
    start_scn();
    send_frame(1, 0, 1'b0);
    send_frame(101, 0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    check("s3_count", 72'(nwin), 72'd8);
    check("s3_done", 72'(ndone), 72'd2);
    check("s3_f2_first", (wq.size() > 4) ? wq[4] : '0, 72'h65_66_67_69_6A_6B_6D_6E_6F);

    // reset after pixel 9, then a fresh frame
    start_scn();
    for (int i = 0; i < 9; i++) step(1'b1, 8'(i + 1), 1'b0);
    do_reset();
    check("s4_rst_win", pack9(o4), 72'd0);
    start_scn();
    send_frame(1, 0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    check("s4_count", 72'(nwin), 72'd4);
    check("s4_first", (wq.size() > 0) ? wq[0] : '0, 72'h01_02_03_05_06_07_09_0A_0B);

    // frame_start on pixel 7, then a flagged full frame
    start_scn();
    for (int i = 0; i < 6; i++) step(1'b1, 8'(i + 1), 1'b0);
    step(1'b1, 8'd7, 1'b1);
    send_frame(1, 0, 1'b1);
    step(1'b0, 8'd0, 1'b0);
    check("s5_count", 72'(nwin), 72'd4);
    check("s5_first", (wq.size() > 0) ? wq[0] : '0, 72'h01_02_03_05_06_07_09_0A_0B);
    check("s5_last", (wq.size() > 3) ? wq[3] : '0, 72'h06_07_08_0A_0B_0C_0E_0F_10);

    // random pixels, random gaps, random mid-frame resync
    start_scn();
    for (int f = 0; f < 3; f++) send_frame(-1, 30, 1'b1);
    step(1'b0, 8'd0, 1'b0);
    check("s6_count", 72'(nwin), 72'd12);
    for (int i = 0; i < 40; i++) begin
      gap(30);
      step(1'b1, 8'($urandom), ($urandom_range(15, 0) == 0));
    end

    // default geometry ramp
    sel = 1; img_w = 28; img_h = 28;
    do_reset();
    start_scn();
    send_frame(0, 0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    check("s7_count", 72'(nwin), 72'd676);
    check("s7_done", 72'(ndone), 72'd1);
    check("s7_first", (wq.size() > 0) ? wq[0] : '0, 72'h00_01_02_1C_1D_1E_38_39_3A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
